// File: rtl/button_step.sv
// Two-button conditioner: sync, debounce and one-cycle step pulses.
// Define BUTTON_STEP_REPEAT_EN to build the hold-to-repeat pulse train.
module button_step #(
    parameter int DEBOUNCE_CYC     = 50000,
    parameter int REPEAT_DELAY_CYC = 25000000,
    parameter int REPEAT_RATE_CYC  = 5000000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_btn_plus,
    input  logic i_btn_minus,
    output logic o_plus,
    output logic o_minus,
    output logic o_held,
    output logic o_lock
);

    localparam int DW = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYC - 1);

    typedef enum logic [1:0] {
        IDLE,
        HOLD_PLUS,
        HOLD_MINUS,
        LOCKOUT
    } state_t;

    state_t     state;
    state_t     state_d;
    logic [1:0] meta;
    logic [1:0] sync;
    logic [1:0] deb;
    logic       deb_p;
    logic       deb_m;
    logic       in_hold;
    logic       rep_due;
    logic       plus_d;
    logic       minus_d;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            meta <= 2'b00;
            sync <= 2'b00;
        end else begin
            meta <= {i_btn_minus, i_btn_plus};
            sync <= meta;
        end
    end

    // Bit 0 is plus, bit 1 is minus.
    for (genvar g = 0; g < 2; g++) begin : g_deb
        logic [DW-1:0] cnt;
        logic          stable;

        always_ff @(posedge i_clk or negedge i_rst) begin
            if (!i_rst) begin
                cnt    <= '0;
                stable <= 1'b0;
            end else if (sync[g] == stable) begin
                cnt <= '0;
            end else if (cnt == DEB_LAST) begin
                cnt    <= '0;
                stable <= ~stable;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end

        assign deb[g] = stable;
    end

    assign deb_p   = deb[0];
    assign deb_m   = deb[1];
    assign in_hold = (state == HOLD_PLUS) || (state == HOLD_MINUS);

`ifdef BUTTON_STEP_REPEAT_EN
    localparam int RMAX = (REPEAT_DELAY_CYC > REPEAT_RATE_CYC) ?
                          REPEAT_DELAY_CYC : REPEAT_RATE_CYC;
    localparam int RW = $clog2(RMAX + 1);
    localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY_CYC - 1);
    localparam logic [RW-1:0] RATE_LAST  = RW'(REPEAT_RATE_CYC - 1);

    logic [RW-1:0] rcnt;
    logic          rep_phase;

    assign rep_due = in_hold &&
                     (rep_phase ? (rcnt == RATE_LAST) : (rcnt == DELAY_LAST));

    // Entry into HOLD happens from a non-hold state, so clearing on
    // !in_hold also restarts the delay for every new press.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            rcnt      <= '0;
            rep_phase <= 1'b0;
        end else if (!in_hold || (state_d != state)) begin
            rcnt      <= '0;
            rep_phase <= 1'b0;
        end else if (rep_due) begin
            rcnt      <= '0;
            rep_phase <= 1'b1;
        end else begin
            rcnt <= rcnt + 1'b1;
        end
    end
`else
    assign rep_due = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state   <= IDLE;
            o_plus  <= 1'b0;
            o_minus <= 1'b0;
        end else begin
            state   <= state_d;
            o_plus  <= plus_d;
            o_minus <= minus_d;
        end
    end

    // The other button rising wins over both release and a due repeat.
    always_comb begin
        state_d = state;
        unique case (state)
            IDLE: begin
                if (deb_p && deb_m)
                    state_d = LOCKOUT;
                else if (deb_p)
                    state_d = HOLD_PLUS;
                else if (deb_m)
                    state_d = HOLD_MINUS;
            end
            HOLD_PLUS: begin
                if (deb_m)
                    state_d = LOCKOUT;
                else if (!deb_p)
                    state_d = IDLE;
            end
            HOLD_MINUS: begin
                if (deb_p)
                    state_d = LOCKOUT;
                else if (!deb_m)
                    state_d = IDLE;
            end
            LOCKOUT: begin
                if (!deb_p && !deb_m)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        plus_d  = 1'b0;
        minus_d = 1'b0;
        unique case (state)
            IDLE: begin
                plus_d  = (state_d == HOLD_PLUS);
                minus_d = (state_d == HOLD_MINUS);
            end
            HOLD_PLUS:  plus_d  = (state_d == HOLD_PLUS) && rep_due;
            HOLD_MINUS: minus_d = (state_d == HOLD_MINUS) && rep_due;
            default: begin
                plus_d  = 1'b0;
                minus_d = 1'b0;
            end
        endcase
    end

    assign o_held = in_hold;
    assign o_lock = (state == LOCKOUT);

endmodule

// File: tb/tb_button_step.sv
// Scoreboard bench for button_step: expected pulses are queued with
// their cycle stamp and popped by a monitor on every observed pulse.
module tb_button_step;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic btn_p = 1'b0;
    logic btn_m = 1'b0;
    logic o_plus;
    logic o_minus;
    logic o_held;
    logic o_lock;

    int cyc   = 0;
    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int cyc;
        bit minus;
    } ev_t;

    ev_t exp_q[$];
    ev_t got;

    button_step #(
        .DEBOUNCE_CYC    (4),
        .REPEAT_DELAY_CYC(20),
        .REPEAT_RATE_CYC (5)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst_n),
        .i_btn_plus (btn_p),
        .i_btn_minus(btn_m),
        .o_plus     (o_plus),
        .o_minus    (o_minus),
        .o_held     (o_held),
        .o_lock     (o_lock)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic act,
                         input logic req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %b want %b (cyc %0d)",
                     name, act, req, cyc);
        end
    endtask

    task automatic expect_pulse(input int at, input bit m);
        exp_q.push_back('{cyc: at, minus: m});
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // Monitor: every pulse must match the head of the queue.
    always @(negedge clk) begin
        if (o_plus && o_minus) begin
            n_cmp++;
            n_bad++;
            $display("FAIL excl: plus and minus both high (cyc %0d)", cyc);
        end
        if (o_plus || o_minus) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected: pulse minus=%b at cyc %0d, none due",
                         o_minus, cyc);
            end else begin
                got = exp_q.pop_front();
                if (got.cyc != cyc || got.minus != o_minus) begin
                    n_bad++;
                    $display("FAIL pulse: got cyc %0d minus=%b want cyc %0d minus=%b",
                             cyc, o_minus, got.cyc, got.minus);
                end
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        int c;
        int r;
        int e;

        // Reset with both buttons held, then lockout and recovery.
        btn_p = 1'b1;
        btn_m = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("rst_plus", o_plus, 1'b0);
            check("rst_minus", o_minus, 1'b0);
            check("rst_held", o_held, 1'b0);
            check("rst_lock", o_lock, 1'b0);
        end
        rst_n = 1'b1;
        c = cyc;
        wait_until(c + 6);
        check("lock_early", o_lock, 1'b0);
        wait_until(c + 7);
        check("lock_set", o_lock, 1'b1);
        check("lock_noheld", o_held, 1'b0);
        btn_p = 1'b0;
        btn_m = 1'b0;
        c = cyc;
        wait_until(c + 6);
        check("lock_stay", o_lock, 1'b1);
        wait_until(c + 7);
        check("lock_clear", o_lock, 1'b0);
        wait_until(cyc + 4);

        // Clean press of plus for 10 cycles.
        c = cyc;
        btn_p = 1'b1;
        expect_pulse(c + 7, 1'b0);
        wait_until(c + 6);
        check("press_notyet", o_held, 1'b0);
        wait_until(c + 7);
        check("press_held", o_held, 1'b1);
        wait_until(c + 10);
        btn_p = 1'b0;
        r = cyc;
        wait_until(r + 6);
        check("rel_held", o_held, 1'b1);
        wait_until(r + 7);
        check("rel_idle", o_held, 1'b0);
        wait_until(cyc + 4);

        // Bouncing minus: runs 3 high, 2 low, 3 high, 1 low, then steady.
        c = cyc;
        btn_m = 1'b1;
        wait_until(c + 3);
        btn_m = 1'b0;
        wait_until(c + 5);
        btn_m = 1'b1;
        wait_until(c + 8);
        btn_m = 1'b0;
        wait_until(c + 9);
        btn_m = 1'b1;
        expect_pulse(c + 16, 1'b1);
        wait_until(c + 15);
        check("bounce_notyet", o_held, 1'b0);
        wait_until(c + 16);
        check("bounce_held", o_held, 1'b1);
        wait_until(c + 20);
        btn_m = 1'b0;
        r = cyc;
        wait_until(r + 7);
        check("bounce_rel", o_held, 1'b0);
        wait_until(cyc + 4);

        // Plus held, then minus joins: lockout until both are released.
        c = cyc;
        btn_p = 1'b1;
        expect_pulse(c + 7, 1'b0);
        wait_until(c + 10);
        btn_m = 1'b1;
        wait_until(c + 16);
        check("both_held", o_held, 1'b1);
        check("both_nolock", o_lock, 1'b0);
        wait_until(c + 17);
        check("both_lock", o_lock, 1'b1);
        check("both_noheld", o_held, 1'b0);
        wait_until(c + 20);
        btn_p = 1'b0;
        wait_until(c + 30);
        check("both_plusrel", o_lock, 1'b1);
        btn_m = 1'b0;
        wait_until(c + 36);
        check("both_stay", o_lock, 1'b1);
        wait_until(c + 37);
        check("both_clear", o_lock, 1'b0);
        wait_until(cyc + 4);

        // Long hold: repeat train when built in, single pulse otherwise.
        c = cyc;
        btn_p = 1'b1;
        e = c + 7;
        expect_pulse(e, 1'b0);
`ifdef BUTTON_STEP_REPEAT_EN
        expect_pulse(e + 20, 1'b0);
        expect_pulse(e + 25, 1'b0);
        expect_pulse(e + 30, 1'b0);
        expect_pulse(e + 35, 1'b0);
        expect_pulse(e + 40, 1'b0);
`endif
        wait_until(e + 36);
        btn_p = 1'b0;
        wait_until(e + 42);
        check("rep_held", o_held, 1'b1);
        wait_until(e + 43);
        check("rep_idle", o_held, 1'b0);
        wait_until(cyc + 6);

        // Reset 12 cycles into a hold, button kept down.
        c = cyc;
        btn_p = 1'b1;
        expect_pulse(c + 7, 1'b0);
        wait_until(c + 12);
        check("mid_held", o_held, 1'b1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_plus", o_plus, 1'b0);
        check("mid_rst_held", o_held, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        r = cyc;
        expect_pulse(r + 7, 1'b0);
        wait_until(r + 6);
        check("mid_notyet", o_held, 1'b0);
        wait_until(r + 7);
        check("mid_held2", o_held, 1'b1);
        wait_until(r + 10);
        btn_p = 1'b0;
        wait_until(cyc + 10);

        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL missing: %0d expected pulses never seen, want 0",
                     exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
